// File: rtl/window_3x3_generator.sv
// -----------------------------------------------------------------------------
// window_3x3_generator
//   Front end of the 3x3 median filter. Consumes a raster-order pixel stream,
//   keeps the two previous rows in line buffers, slides a 3x3 window and hands
//   each interior window to the 9-input sorter through a start/valid handshake.
//
// Parameters
//   IMG_WIDTH   pixels per row   (>= 3)
//   IMG_HEIGHT  rows per frame   (>= 3)
//   Pixel width comes from the BIT_WIDTH macro (8 if not provided).
//
// Ports
//   CLK           in   clock, rising edge
//   RST           in   asynchronous reset, active low
//   pix_valid_i   in   pixel present on pix_data_i
//   pix_data_i    in   pixel, raster order
//   pix_ready_o   out  pixel accepted when pix_valid_i & pix_ready_o
//   win0_o..win8_o out window, row-major, win0=(r-2,c-2) .. win8=(r,c)
//   start_o       out  request to sorter (start_i)
//   sort_valid_i  in   sorter done (valid_o)
//   frame_done_o  out  one-cycle pulse after the last window of a frame
//                      (present only when WIN_FRAME_DONE_EN is defined)
//
// Optional feature macro: WIN_FRAME_DONE_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module window_3x3_generator #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pix_valid_i,
  input  logic [`BIT_WIDTH-1:0] pix_data_i,
  output logic                  pix_ready_o,
  output logic [`BIT_WIDTH-1:0] win0_o,
  output logic [`BIT_WIDTH-1:0] win1_o,
  output logic [`BIT_WIDTH-1:0] win2_o,
  output logic [`BIT_WIDTH-1:0] win3_o,
  output logic [`BIT_WIDTH-1:0] win4_o,
  output logic [`BIT_WIDTH-1:0] win5_o,
  output logic [`BIT_WIDTH-1:0] win6_o,
  output logic [`BIT_WIDTH-1:0] win7_o,
  output logic [`BIT_WIDTH-1:0] win8_o,
  output logic                  start_o,
  input  logic                  sort_valid_i
`ifdef WIN_FRAME_DONE_EN
  ,
  output logic                  frame_done_o
`endif
);

  localparam int PW    = `BIT_WIDTH;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             transfer;
  logic             emit;
  logic [PW-1:0]    lb0 [IMG_WIDTH];   // row r-1
  logic [PW-1:0]    lb1 [IMG_WIDTH];   // row r-2
  logic [PW-1:0]    lb0_rd;
  logic [PW-1:0]    lb1_rd;
  logic [PW-1:0]    win [9];
  logic             start;
  logic             pix_ready;

  // Accept a pixel only while idle; read both line buffers at the current column.
  always_comb begin
    transfer = pix_valid_i && (state == ACCEPT);
    emit     = transfer && (row >= ROW_TWO) && (col >= COL_TWO);
    lb0_rd   = lb0[col];
    lb1_rd   = lb1[col];
  end

  // Next-state logic of the sorter handshake.
  always_comb begin
    next_state = state;
    case (state)
      ACCEPT: begin
        if (emit) next_state = REQ;
        else      next_state = ACCEPT;
      end
      REQ: begin
        // A sorter that already reports valid releases us after one cycle.
        if (sort_valid_i) next_state = RELEASE;
        else              next_state = REQ;
      end
      RELEASE: begin
        // Wait for valid to drop so the next start is seen as a new request.
        if (!sort_valid_i) next_state = ACCEPT;
        else               next_state = RELEASE;
      end
      default: next_state = ACCEPT;
    endcase
  end

  // State register with registered handshake outputs derived from next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ACCEPT;
      start     <= 1'b0;
      pix_ready <= 1'b1;
    end else begin
      state     <= next_state;
      start     <= (next_state == REQ);
      pix_ready <= (next_state == ACCEPT);
    end
  end

  // Column/row position of the next pixel; wraps only at the image bounds.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col <= COL_ZERO;
      row <= ROW_ZERO;
    end else if (transfer) begin
      if (col == COL_LAST) begin
        col <= COL_ZERO;
        if (row == ROW_LAST) row <= ROW_ZERO;
        else                 row <= row + ROW_ONE;
      end else begin
        col <= col + COL_ONE;
      end
    end else begin
      col <= col;
      row <= row;
    end
  end

  // Line buffers: row r-1 ages into row r-2, the new pixel becomes row r-1.
  always_ff @(posedge CLK) begin
    if (transfer) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= pix_data_i;
    end
  end

  // Sliding window; only moves on a transfer, so it is frozen in REQ/RELEASE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 9; i++) win[i] <= {PW{1'b0}};
    end else if (transfer) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_rd;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_rd;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix_data_i;
    end else begin
      for (int i = 0; i < 9; i++) win[i] <= win[i];
    end
  end

`ifdef WIN_FRAME_DONE_EN
  logic frame_done;

  // The only window whose transfer wraps both counters to zero is the last one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == RELEASE) && (next_state == ACCEPT) &&
                    (row == ROW_ZERO) && (col == COL_ZERO);
    end
  end

  assign frame_done_o = frame_done;
`endif

  assign pix_ready_o = pix_ready;
  assign start_o     = start;
  assign win0_o      = win[0];
  assign win1_o      = win[1];
  assign win2_o      = win[2];
  assign win3_o      = win[3];
  assign win4_o      = win[4];
  assign win5_o      = win[5];
  assign win6_o      = win[6];
  assign win7_o      = win[7];
  assign win8_o      = win[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_generator
//   Directed bench for a 4x4 image carrying pixels 1..16. Each task drives one
//   scenario and compares the outputs against hand-computed windows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module tb_window_3x3_generator;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = `BIT_WIDTH;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_ready;
  logic          start;
  logic          sort_valid;
  logic [PW-1:0] win_obs [9];
`ifdef WIN_FRAME_DONE_EN
  logic          frame_done;
`endif

  int errors = 0;
  int checks = 0;

  // Hand-computed windows of a 4x4 frame with pixels 1..16.
  logic [PW-1:0] exp_tab [4][9] = '{
    '{PW'(1), PW'(2), PW'(3), PW'(5),  PW'(6),  PW'(7),  PW'(9),  PW'(10), PW'(11)},
    '{PW'(2), PW'(3), PW'(4), PW'(6),  PW'(7),  PW'(8),  PW'(10), PW'(11), PW'(12)},
    '{PW'(5), PW'(6), PW'(7), PW'(9),  PW'(10), PW'(11), PW'(13), PW'(14), PW'(15)},
    '{PW'(6), PW'(7), PW'(8), PW'(10), PW'(11), PW'(12), PW'(14), PW'(15), PW'(16)}
  };

  window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK         (clk),
    .RST         (rst),
    .pix_valid_i (pix_valid),
    .pix_data_i  (pix_data),
    .pix_ready_o (pix_ready),
    .win0_o      (win_obs[0]),
    .win1_o      (win_obs[1]),
    .win2_o      (win_obs[2]),
    .win3_o      (win_obs[3]),
    .win4_o      (win_obs[4]),
    .win5_o      (win_obs[5]),
    .win6_o      (win_obs[6]),
    .win7_o      (win_obs[7]),
    .win8_o      (win_obs[8]),
    .start_o     (start),
    .sort_valid_i(sort_valid)
`ifdef WIN_FRAME_DONE_EN
    ,
    .frame_done_o(frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one pixel for one edge; sort_valid is driven alongside it.
  task automatic stream_pixel(input int v, input bit sv);
    pix_valid  = 1'b1;
    pix_data   = PW'(v);
    sort_valid = sv;
    tick();
    pix_valid  = 1'b0;
  endtask

  // Called at the negedge after a window-producing transfer.
  task automatic serve_window(input int idx, input int latency);
    bit bad;
    checks++;
    if (start !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL win%0d_start: start=%b ready=%b, required start=1 ready=0", idx, start, pix_ready);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (win_obs[k] !== exp_tab[idx][k]) begin
        errors++;
        $display("FAIL win%0d_w%0d: got %0d, required %0d", idx, k, win_obs[k], exp_tab[idx][k]);
      end
    end
    for (int c = 0; c < latency; c++) begin
      sort_valid = 1'b0;
      tick();
      checks++;
      if (start !== 1'b1 || pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL win%0d_req_hold c%0d: start=%b ready=%b, required 1/0", idx, c, start, pix_ready);
      end
      bad = 1'b0;
      for (int k = 0; k < 9; k++) if (win_obs[k] !== exp_tab[idx][k]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL win%0d_frozen c%0d: window changed, required %0d..%0d", idx, c, exp_tab[idx][0], exp_tab[idx][8]);
      end
    end
    sort_valid = 1'b1;
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL win%0d_release: start=%b ready=%b, required 0/0", idx, start, pix_ready);
    end
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL win%0d_release_hold: start=%b ready=%b, required 0/0", idx, start, pix_ready);
    end
    sort_valid = 1'b0;
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL win%0d_accept: start=%b ready=%b, required 0/1", idx, start, pix_ready);
    end
`ifdef WIN_FRAME_DONE_EN
    checks++;
    if (frame_done !== (idx == 3)) begin
      errors++;
      $display("FAIL win%0d_frame_done: got %b, required %b", idx, frame_done, (idx == 3));
    end
    if (idx == 3) begin
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_width: got %b, required 0", frame_done);
      end
    end
`endif
  endtask

  // Stream one full frame; pre puts sort_valid high before the window transfer,
  // spur holds sort_valid high during border pixels.
  task automatic run_frame(input int latency, input bit pre, input bit spur);
    int idx;
    idx = 0;
    for (int v = 1; v <= W * H; v++) begin
      if ((((v - 1) / W) >= 2) && (((v - 1) % W) >= 2)) begin
        stream_pixel(v, pre);
        serve_window(idx, latency);
        idx++;
      end else begin
        stream_pixel(v, spur);
        checks++;
        if (start !== 1'b0 || pix_ready !== 1'b1) begin
          errors++;
          $display("FAIL border_pix%0d: start=%b ready=%b, required 0/1", v, start, pix_ready);
        end
`ifdef WIN_FRAME_DONE_EN
        checks++;
        if (frame_done !== 1'b0) begin
          errors++;
          $display("FAIL border_pix%0d_frame_done: got %b, required 0", v, frame_done);
        end
`endif
      end
    end
    sort_valid = 1'b0;
  endtask

  task automatic test_reset();
    pix_valid  = 1'b0;
    pix_data   = '0;
    sort_valid = 1'b0;
    rst        = 1'b1;
    #1 rst     = 1'b0;
    tick();
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: start=%b ready=%b, required 0/1", start, pix_ready);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (win_obs[k] !== '0) begin
        errors++;
        $display("FAIL reset_w%0d: got %0d, required 0", k, win_obs[k]);
      end
    end
`ifdef WIN_FRAME_DONE_EN
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b, required 0", frame_done);
    end
`endif
    rst = 1'b1;
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_hs: start=%b ready=%b, required 0/1", start, pix_ready);
    end
  endtask

  task automatic test_first_frame();
    run_frame(12, 1'b0, 1'b0);
  endtask

  task automatic test_second_frame();
    run_frame(1, 1'b0, 1'b0);
  endtask

  task automatic test_early_valid();
    run_frame(0, 1'b1, 1'b0);
  endtask

  task automatic test_spurious_valid();
    sort_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (start !== 1'b0 || pix_ready !== 1'b1) begin
        errors++;
        $display("FAIL spurious_idle c%0d: start=%b ready=%b, required 0/1", c, start, pix_ready);
      end
    end
    sort_valid = 1'b0;
    run_frame(2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_window();
    for (int v = 1; v <= 10; v++) stream_pixel(v, 1'b0);
    stream_pixel(11, 1'b0);
    serve_window(0, 3);
    stream_pixel(12, 1'b0);
    checks++;
    if (start !== 1'b1 || win_obs[8] !== PW'(12)) begin
      errors++;
      $display("FAIL mid_req: start=%b w8=%0d, required 1/12", start, win_obs[8]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (start !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_hs: start=%b ready=%b, required 0/1", start, pix_ready);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (win_obs[k] !== '0) begin
        errors++;
        $display("FAIL mid_reset_w%0d: got %0d, required 0", k, win_obs[k]);
      end
    end
    rst = 1'b1;
    tick();
    run_frame(4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_early_valid();
    test_spurious_valid();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
